// File: rtl/ifetch_pkg.sv
// Shared CPU definitions used by the fetch stage: datapath width, reset PC
// default and the fetch state encoding.
package ifetch_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, drives program memory reads and hands each
// returned word (with its PC) to decode over a valid/ready handshake.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int                ADDR_BITS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [WORD_W-1:0] mem_address,
    output logic              mem_oen_n,
    input  logic [WORD_W-1:0] mem_data,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              busy
);

    // The full 16-bit PC is always driven; memory decodes only the low bits.
    if (ADDR_BITS < 1 || ADDR_BITS > WORD_W) begin : g_bad_addr_bits
        $error("ifetch: ADDR_BITS must be in 1..16");
    end

    state_t            state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pend_pc;
    logic              pend;
    logic              slot_free;
    logic              issue;

    assign slot_free   = !pend || instr_ready;
    assign issue       = (state == ST_RUN && slot_free) || redirect;
    assign mem_oen_n   = !issue;
    assign mem_address = redirect ? redirect_pc : pc;
    assign instr       = mem_data;
    assign instr_pc    = pend_pc;
    assign instr_valid = pend && !redirect;
    assign busy        = (state != ST_IDLE) || pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            pend    <= 1'b0;
            pend_pc <= '0;
            state   <= ST_IDLE;
        end else if (redirect) begin
            // The word sitting in mem_data is simply overwritten by the new read.
            pend    <= 1'b1;
            pend_pc <= redirect_pc;
            pc      <= redirect_pc + 16'd1;
            state   <= run ? ST_RUN : ST_DRAIN;
        end else begin
            if (issue) begin
                pend    <= 1'b1;
                pend_pc <= pc;
                pc      <= pc + 16'd1;
            end else if (pend && instr_ready) begin
                pend <= 1'b0;
            end

            case (state)
                ST_IDLE:  if (run) state <= ST_RUN;
                ST_RUN:   if (!run) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (run)       state <= ST_RUN;
                    else if (!pend) state <= ST_IDLE;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios then random run/ready/redirect traffic,
// checked against a program-order model of which words decode must accept.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] mem_address;
    logic        mem_oen_n;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        busy;

    logic [15:0] mem [1024];

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] exp_pc;
    logic        prev_stall;
    logic [15:0] hold_instr;
    logic [15:0] hold_pc;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(16'h0000), .ADDR_BITS(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_address (mem_address),
        .mem_oen_n   (mem_oen_n),
        .mem_data    (mem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .busy        (busy)
    );

    // Program memory: one-cycle registered read, output holds when not enabled.
    always @(posedge clk) begin
        if (!mem_oen_n) mem_data <= mem[mem_address[9:0]];
    end

    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [9:0] lo;
        lo = a[9:0];
        return 16'h1000 + {6'b0, lo};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    endtask

    // One clock of handshake checking; inputs were set by the caller at negedge.
    task automatic tick();
        #1;
        if (prev_stall && !redirect) begin
            check("hold_valid", instr_valid, 1);
            check("hold_instr", instr, hold_instr);
            check("hold_pc", instr_pc, hold_pc);
        end
        if (redirect) begin
            check("redir_valid", instr_valid, 0);
            check("redir_oen", mem_oen_n, 0);
            check("redir_addr", mem_address, redirect_pc);
        end else begin
            if (instr_valid && instr_ready) begin
                check("acc_pc", instr_pc, exp_pc);
                check("acc_instr", instr, word_at(exp_pc));
                exp_pc = exp_pc + 16'd1;
            end
            if (instr_valid && !instr_ready) check("stall_oen", mem_oen_n, 1);
        end
        if (instr_valid) check("valid_busy", busy, 1);
        prev_stall = instr_valid && !instr_ready && !redirect;
        hold_instr = instr;
        hold_pc    = instr_pc;
        if (redirect) exp_pc = redirect_pc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        #1;
        while (!instr_valid && n < max_cyc) begin
            tick();
            n++;
            #1;
        end
        check("wait_valid", instr_valid, 1);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);
        rst = 1'b1; run = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        prev_stall = 1'b0; exp_pc = 16'h0000;
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_valid", instr_valid, 0);
        check("rst_oen", mem_oen_n, 1);
        check("rst_busy", busy, 0);
        check("rst_addr", mem_address, 16'h0000);
        check("rst_ipc", instr_pc, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // 1: start-up latency and back-to-back stream
        run = 1'b1; instr_ready = 1'b1;
        #1 check("s1_v_c0", instr_valid, 0);
        check("s1_oen_c0", mem_oen_n, 1);
        tick();
        #1 check("s1_v_c1", instr_valid, 0);
        check("s1_oen_c1", mem_oen_n, 0);
        check("s1_addr_c1", mem_address, 16'h0000);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1 check("s1_valid", instr_valid, 1);
            check("s1_pc", instr_pc, 16'(i));
            check("s1_instr", instr, 16'h1000 + 16'(i));
            tick();
        end

        // 2: back-pressure on 1005
        cnt = 0;
        #1;
        while (!(instr_valid && instr_pc == 16'h0005) && cnt < 10) begin tick(); cnt++; #1; end
        check("s2_reach5", instr_pc, 16'h0005);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("s2_oen", mem_oen_n, 1);
            check("s2_instr", instr, 16'h1005);
            check("s2_pc", instr_pc, 16'h0005);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        #1 check("s2_next_v", instr_valid, 1);
        check("s2_next", instr, 16'h1006);

        // 3: redirect drops the pending word
        tick();
        #1 check("s3_pend_pc", instr_pc, 16'h0007);
        redirect = 1'b1; redirect_pc = 16'h0200;
        #1 check("s3_drop", instr_valid, 0);
        tick();
        redirect = 1'b0;
        #1 check("s3_pc0", instr_pc, 16'h0200);
        check("s3_i0", instr, 16'h1200);
        tick();
        #1 check("s3_pc1", instr_pc, 16'h0201);
        check("s3_i1", instr, 16'h1201);
        tick();

        // 4: run drops while streaming; the in-flight read still arrives
        run = 1'b0;
        tick();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1 check("s4_oen", mem_oen_n, 1);
            if (instr_valid) cnt++;
            tick();
        end
        check("s4_count", cnt, 1);
        #1 check("s4_busy", busy, 0);
        check("s4_idle_valid", instr_valid, 0);
        run = 1'b1;
        wait_valid(10);
        check("s4_resume_pc", instr_pc, 16'h0204);

        // 5: asynchronous reset mid-stream
        #1 check("s5_pre_valid", instr_valid, 1);
        rst = 1'b1;
        #1 check("s5_async_valid", instr_valid, 0);
        check("s5_async_busy", busy, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; exp_pc = 16'h0000; prev_stall = 1'b0;
        wait_valid(10);
        check("s5_restart_pc", instr_pc, 16'h0000);

        // 6: PC wrap at FFFF with aliased memory data
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        #1 check("s6_pc_ffff", instr_pc, 16'hFFFF);
        check("s6_i_ffff", instr, 16'h13FF);
        tick();
        #1 check("s6_pc_0", instr_pc, 16'h0000);
        check("s6_i_0", instr, 16'h1000);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            run         = ($urandom_range(0, 9) != 0);
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                      : 16'($urandom);
            tick();
        end
        redirect = 1'b0; run = 1'b1; instr_ready = 1'b1;
        wait_valid(10);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
